// File: rtl/minibus_pkg.sv
// Shared minibus types: request/response packs, master FSM state encoding
// and the upper bound on slave ports an interconnect may decode.
package minibus_pkg;

    localparam int MINIBUS_MAX_SLAVES = 16;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } minibus_req_pack;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } minibus_res_pack;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } minibus_master_state_e;

endpackage

// File: rtl/minibus_addr_decode.sv
// Combinational minibus address decoder.
// Ports:
//   addr_i   - address to decode
//   onehot_o - one-hot slave select; lowest matching index wins on overlap
//   hit_o    - at least one region matched
module minibus_addr_decode
    import minibus_pkg::*;
#(
    parameter int          NUM_SLAVES            = 4,
    parameter logic [31:0] SLV_BASE [NUM_SLAVES] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000},
    parameter logic [31:0] SLV_MASK [NUM_SLAVES] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}
) (
    input  logic [31:0]           addr_i,
    output logic [NUM_SLAVES-1:0] onehot_o,
    output logic                  hit_o
);

    // Walk from the highest index down so the lowest matching index is the
    // last one written and therefore wins.
    always_comb begin
        onehot_o = '0;
        hit_o    = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[i]) == SLV_BASE[i]) begin
                onehot_o = NUM_SLAVES'(1) << i;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/minibus_master.sv
// Single-initiator minibus master with address decode and wait-state timeout.
// Ports:
//   clk, nrst             - clock, synchronous active-high reset
//   cpu_valid/ready/req   - core request channel (ready only in IDLE)
//   rsp_valid/ready/rsp   - response channel; rsp.ready mirrors rsp_valid
//   sel                   - one-hot slave select, high only during ACCESS
//   s_req                 - registered request broadcast to all slaves
//   s_res                 - per-slave responses, only the selected one is used
module minibus_master
    import minibus_pkg::*;
#(
    parameter int          NUM_SLAVES            = 4,
    parameter logic [31:0] SLV_BASE [NUM_SLAVES] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000},
    parameter logic [31:0] SLV_MASK [NUM_SLAVES] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int          TIMEOUT               = 16
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             cpu_valid,
    output logic                             cpu_ready,
    input  minibus_req_pack                  cpu_req,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output minibus_res_pack                  rsp,
    output logic [NUM_SLAVES-1:0]            sel,
    output minibus_req_pack                  s_req,
    input  minibus_res_pack [NUM_SLAVES-1:0] s_res
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    minibus_master_state_e state_q;
    logic [NUM_SLAVES-1:0] sel_q;
    minibus_req_pack       s_req_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_error_q;
    logic                  rsp_valid_q;
    logic                  cpu_ready_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [NUM_SLAVES-1:0] dec_onehot;
    logic                  dec_hit;
    minibus_res_pack       sel_res;
    logic                  one_op;

    minibus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .addr_i   (cpu_req.addr),
        .onehot_o (dec_onehot),
        .hit_o    (dec_hit)
    );

    // sel_q is one-hot or zero, so an OR-reduction is a clean mux that also
    // masks off every unselected slave.
    always_comb begin
        sel_res = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_res = sel_res | s_res[i];
            end
        end
    end

    assign one_op = cpu_req.ren ^ cpu_req.wen;

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            s_req_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            cpu_ready_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        s_req_q     <= cpu_req;
                        cpu_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        if (one_op && dec_hit) begin
                            sel_q   <= dec_onehot;
                            state_q <= ACCESS;
                        end else begin
                            // No-op requests complete cleanly; unmapped or
                            // read+write requests are rejected with error.
                            rsp_rdata_q <= '0;
                            rsp_error_q <= cpu_req.ren | cpu_req.wen;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // A ready on the last counted cycle still wins over timeout.
                    if (sel_res.ready) begin
                        rsp_rdata_q <= s_req_q.wen ? 32'h0 : sel_res.rdata;
                        rsp_error_q <= sel_res.error;
                        sel_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b1;
                        sel_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    sel_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    cpu_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign sel       = sel_q;
    assign s_req     = s_req_q;

    always_comb begin
        rsp       = '0;
        rsp.ready = rsp_valid_q;
        rsp.rdata = rsp_rdata_q;
        rsp.error = rsp_error_q;
    end

endmodule

// File: tb/tb_minibus_master.sv
module tb_minibus_master;
    import minibus_pkg::*;

    localparam int NS = 4;
    localparam int TO = 16;
    // Slave 3 overlaps slave 2 (0x2xxx_xxxx) so lowest-index priority is exercised.
    localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000};
    localparam logic [31:0] MASK [NS] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hE000_0000};

    logic                     clk, nrst, cpu_valid, cpu_ready, rsp_valid, rsp_ready;
    minibus_req_pack          cpu_req, s_req;
    minibus_res_pack          rsp;
    logic [NS-1:0]            sel;
    minibus_res_pack [NS-1:0] s_res;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural slaves: ready after slv_wait cycles of sel, or never.
    int          slv_wait  [NS];
    logic        slv_never [NS];
    logic [31:0] slv_rdata [NS];
    logic        slv_err   [NS];
    int          wcnt      [NS];
    logic [NS-1:0] noise;

    minibus_master #(
        .NUM_SLAVES (NS),
        .SLV_BASE   (BASE),
        .SLV_MASK   (MASK),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_req   (cpu_req),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp       (rsp),
        .sel       (sel),
        .s_req     (s_req),
        .s_res     (s_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) wcnt[i] <= sel[i] ? wcnt[i] + 1 : 0;
    end

    always @(negedge clk) noise <= NS'($urandom);

    always_comb begin
        s_res = '0;
        for (int i = 0; i < NS; i++) begin
            if (sel[i]) begin
                s_res[i].ready = !slv_never[i] && (wcnt[i] == slv_wait[i]);
                s_res[i].rdata = slv_rdata[i];
                s_res[i].error = slv_err[i];
            end else begin
                // Unselected slaves babble; the master must ignore them.
                s_res[i].ready = noise[i];
                s_res[i].rdata = 32'hBAD0_0000 | 32'(i);
                s_res[i].error = 1'b1;
            end
        end
    end

    function automatic minibus_req_pack rand_req();
        minibus_req_pack r;
        r.ren   = 1'($urandom);
        r.wen   = 1'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.wstrb = 4'($urandom);
        return r;
    endfunction

    function automatic minibus_req_pack mk_req(input logic ren, input logic wen, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] wstrb);
        minibus_req_pack r;
        r.ren = ren; r.wen = wen; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
        return r;
    endfunction

    // Reference: which slave (or none), cycles from accept to rsp_valid, response data.
    function automatic void model(input minibus_req_pack r, output int idx, output int t,
                                  output logic [31:0] rd, output logic er);
        idx = -1; t = 0; rd = '0; er = 1'b0;
        if (!r.ren && !r.wen) return;
        for (int i = 0; i < NS; i++) begin
            if ((r.addr & MASK[i]) == BASE[i]) begin idx = i; break; end
        end
        if (idx < 0 || (r.ren && r.wen)) begin idx = -1; er = 1'b1; return; end
        if (slv_never[idx] || slv_wait[idx] >= TO) begin t = TO; er = 1'b1; return; end
        t  = slv_wait[idx] + 1;
        rd = r.wen ? 32'h0 : slv_rdata[idx];
        er = slv_err[idx];
    endfunction

    function automatic minibus_res_pack exp_res(input logic [31:0] rd, input logic er);
        minibus_res_pack p;
        p.ready = 1'b1; p.rdata = rd; p.error = er;
        return p;
    endfunction

    // Drives one transaction and records what was observed; checks are done by callers.
    task automatic run_txn(input minibus_req_pack r, input int hold,
                           output int t_rsp, output int sel_cyc, output logic [NS-1:0] sel_seen,
                           output int proto_bad, output minibus_res_pack got, output logic back_idle);
        int c;
        t_rsp = -1; sel_cyc = 0; sel_seen = '0; proto_bad = 0; got = '0; back_idle = 1'b0;
        @(negedge clk);
        if (cpu_ready !== 1'b1) proto_bad++;
        cpu_req   = r;
        cpu_valid = 1'b1;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        cpu_req   = rand_req();
        c = 0;
        while (t_rsp < 0 && c < 4 * TO) begin
            @(negedge clk);
            if (sel !== '0) begin
                sel_cyc++;
                if (sel_seen == '0) sel_seen = sel;
                else if (sel !== sel_seen) proto_bad++;
                if ($countones(sel) != 1) proto_bad++;
            end
            if (rsp_valid !== 1'b1 && s_req !== r) proto_bad++;
            if (cpu_ready !== 1'b0) proto_bad++;
            if (rsp_valid === 1'b1) begin t_rsp = c; got = rsp; end
            c++;
        end
        if (t_rsp >= 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (rsp !== got || rsp_valid !== 1'b1 || cpu_ready !== 1'b0) proto_bad++;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            back_idle = (cpu_ready === 1'b1) && (rsp_valid === 1'b0);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1; cpu_valid = 1'b0; rsp_ready = 1'b0; cpu_req = '0;
        for (int i = 0; i < NS; i++) begin
            slv_wait[i] = 0; slv_never[i] = 1'b0; slv_rdata[i] = '0; slv_err[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sel !== '0)        begin n_mis++; $display("FAIL reset_sel: got %b expected 0", sel); end
        n_cmp++; if (s_req !== '0)      begin n_mis++; $display("FAIL reset_s_req: got %h expected 0", s_req); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp !== '0)        begin n_mis++; $display("FAIL reset_rsp: got %h expected 0", rsp); end
        nrst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cpu_ready !== 1'b1) begin n_mis++; $display("FAIL reset_cpu_ready: got %b expected 1", cpu_ready); end
    endtask

    task automatic test_read_zero_wait();
        int t, sc, pb; logic [NS-1:0] ss; minibus_res_pack g; logic bi;
        slv_wait[1] = 0; slv_rdata[1] = 32'hDEAD_BEEF; slv_err[1] = 1'b0;
        run_txn(mk_req(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0), 0, t, sc, ss, pb, g, bi);
        n_cmp++; if (t !== 1)           begin n_mis++; $display("FAIL rd0_latency: got %0d expected 1", t); end
        n_cmp++; if (sc !== 1 || ss !== 4'b0010) begin n_mis++; $display("FAIL rd0_sel: got %b x%0d expected 0010 x1", ss, sc); end
        n_cmp++; if (g !== exp_res(32'hDEAD_BEEF, 1'b0)) begin n_mis++; $display("FAIL rd0_rsp: got %h expected %h", g, exp_res(32'hDEAD_BEEF, 1'b0)); end
        n_cmp++; if (pb !== 0 || bi !== 1'b1) begin n_mis++; $display("FAIL rd0_protocol: got %0d/%b expected 0/1", pb, bi); end
    endtask

    task automatic test_write_wait3();
        int t, sc, pb; logic [NS-1:0] ss; minibus_res_pack g; logic bi;
        slv_wait[2] = 3; slv_rdata[2] = 32'hCAFE_F00D; slv_err[2] = 1'b0;
        run_txn(mk_req(1'b0, 1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011), 0, t, sc, ss, pb, g, bi);
        n_cmp++; if (t !== 4)           begin n_mis++; $display("FAIL wr3_latency: got %0d expected 4", t); end
        n_cmp++; if (sc !== 4 || ss !== 4'b0100) begin n_mis++; $display("FAIL wr3_sel: got %b x%0d expected 0100 x4", ss, sc); end
        n_cmp++; if (g !== exp_res(32'h0, 1'b0)) begin n_mis++; $display("FAIL wr3_rsp: got %h expected %h", g, exp_res(32'h0, 1'b0)); end
        n_cmp++; if (pb !== 0 || bi !== 1'b1) begin n_mis++; $display("FAIL wr3_protocol: got %0d/%b expected 0/1", pb, bi); end
    endtask

    task automatic test_unmapped();
        int t, sc, pb; logic [NS-1:0] ss; minibus_res_pack g; logic bi;
        run_txn(mk_req(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0), 0, t, sc, ss, pb, g, bi);
        n_cmp++; if (t !== 0)  begin n_mis++; $display("FAIL unmap_latency: got %0d expected 0", t); end
        n_cmp++; if (sc !== 0) begin n_mis++; $display("FAIL unmap_sel: got %0d sel cycles expected 0", sc); end
        n_cmp++; if (g !== exp_res(32'h0, 1'b1)) begin n_mis++; $display("FAIL unmap_rsp: got %h expected %h", g, exp_res(32'h0, 1'b1)); end
    endtask

    task automatic test_timeout_back_to_back();
        int t, sc, pb; logic [NS-1:0] ss; minibus_res_pack g; logic bi;
        slv_never[0] = 1'b1;
        run_txn(mk_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0), 0, t, sc, ss, pb, g, bi);
        slv_never[0] = 1'b0;
        n_cmp++; if (t !== TO)  begin n_mis++; $display("FAIL tmo_latency: got %0d expected %0d", t, TO); end
        n_cmp++; if (sc !== TO || ss !== 4'b0001) begin n_mis++; $display("FAIL tmo_sel: got %b x%0d expected 0001 x%0d", ss, sc, TO); end
        n_cmp++; if (g !== exp_res(32'h0, 1'b1)) begin n_mis++; $display("FAIL tmo_rsp: got %h expected %h", g, exp_res(32'h0, 1'b1)); end
        slv_wait[3] = 1; slv_rdata[3] = 32'h3333_AAAA; slv_err[3] = 1'b0;
        run_txn(mk_req(1'b1, 1'b0, 32'h3000_0008, 32'h0, 4'h0), 0, t, sc, ss, pb, g, bi);
        n_cmp++; if (t !== 2 || ss !== 4'b1000) begin n_mis++; $display("FAIL b2b_slv3: got t=%0d sel=%b expected t=2 sel=1000", t, ss); end
        n_cmp++; if (g !== exp_res(32'h3333_AAAA, 1'b0)) begin n_mis++; $display("FAIL b2b_rsp: got %h expected %h", g, exp_res(32'h3333_AAAA, 1'b0)); end
    endtask

    task automatic test_ready_at_timeout();
        int t, sc, pb; logic [NS-1:0] ss; minibus_res_pack g; logic bi;
        slv_wait[1] = TO - 1; slv_rdata[1] = 32'h0BAD_CAFE; slv_err[1] = 1'b0;
        run_txn(mk_req(1'b1, 1'b0, 32'h1000_0040, 32'h0, 4'h0), 0, t, sc, ss, pb, g, bi);
        n_cmp++; if (t !== TO || g !== exp_res(32'h0BAD_CAFE, 1'b0)) begin n_mis++; $display("FAIL edge_ready_wins: got t=%0d rsp=%h expected t=%0d rsp=%h", t, g, TO, exp_res(32'h0BAD_CAFE, 1'b0)); end
        slv_wait[1] = TO;
        run_txn(mk_req(1'b1, 1'b0, 32'h1000_0040, 32'h0, 4'h0), 0, t, sc, ss, pb, g, bi);
        n_cmp++; if (t !== TO || g !== exp_res(32'h0, 1'b1)) begin n_mis++; $display("FAIL edge_late_ready: got t=%0d rsp=%h expected t=%0d rsp=%h", t, g, TO, exp_res(32'h0, 1'b1)); end
    endtask

    task automatic test_backpressure();
        int t, sc, pb; logic [NS-1:0] ss; minibus_res_pack g; logic bi;
        slv_wait[2] = 1; slv_rdata[2] = 32'h5555_0001; slv_err[2] = 1'b1;
        run_txn(mk_req(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'h0), 5, t, sc, ss, pb, g, bi);
        n_cmp++; if (g !== exp_res(32'h5555_0001, 1'b1)) begin n_mis++; $display("FAIL bp_rsp: got %h expected %h", g, exp_res(32'h5555_0001, 1'b1)); end
        n_cmp++; if (pb !== 0)     begin n_mis++; $display("FAIL bp_stable: got %0d violations expected 0", pb); end
        n_cmp++; if (bi !== 1'b1) begin n_mis++; $display("FAIL bp_return_idle: got %b expected 1", bi); end
    endtask

    task automatic test_reset_mid_access();
        int t, sc, pb, bad; logic [NS-1:0] ss; minibus_res_pack g; logic bi;
        slv_never[1] = 1'b1;
        @(negedge clk);
        cpu_req = mk_req(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0); cpu_valid = 1'b1;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (sel !== 4'b0010) begin n_mis++; $display("FAIL rst_mid_sel_before: got %b expected 0010", sel); end
        nrst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (sel !== '0 || s_req !== '0 || rsp_valid !== 1'b0 || rsp !== '0)
            begin n_mis++; $display("FAIL rst_mid_outputs: got sel=%b s_req=%h rv=%b rsp=%h expected all 0", sel, s_req, rsp_valid, rsp); end
        nrst = 1'b0;
        slv_never[1] = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cpu_ready !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL rst_mid_no_rsp: got %0d bad cycles expected 0", bad); end
        slv_wait[2] = 0; slv_rdata[2] = 32'h0000_2222; slv_err[2] = 1'b0;
        run_txn(mk_req(1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'h0), 0, t, sc, ss, pb, g, bi);
        n_cmp++; if (t !== 1 || g !== exp_res(32'h0000_2222, 1'b0) || pb !== 0)
            begin n_mis++; $display("FAIL rst_mid_next: got t=%0d rsp=%h pb=%0d expected t=1 rsp=%h pb=0", t, g, pb, exp_res(32'h0000_2222, 1'b0)); end
    endtask

    task automatic test_random();
        minibus_req_pack r; minibus_res_pack g, e;
        int idx, et, hold, t, sc, pb; logic [31:0] erd; logic eer, bi; logic [NS-1:0] es, ss;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NS; i++) begin
                slv_wait[i]  = int'($urandom_range(0, TO + 1));
                slv_never[i] = ($urandom_range(0, 7) == 0);
                slv_rdata[i] = $urandom;
                slv_err[i]   = 1'($urandom);
            end
            r = rand_req();
            r.addr[31:28] = 4'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 3));
            model(r, idx, et, erd, eer);
            es = (idx >= 0) ? (NS'(1) << idx) : '0;
            e  = exp_res(erd, eer);
            run_txn(r, hold, t, sc, ss, pb, g, bi);
            n_cmp++; if (t !== et)  begin n_mis++; $display("FAIL rand_latency n=%0d: got %0d expected %0d", n, t, et); end
            n_cmp++; if (ss !== es || sc !== ((idx >= 0) ? et : 0))
                begin n_mis++; $display("FAIL rand_sel n=%0d: got %b x%0d expected %b x%0d", n, ss, sc, es, (idx >= 0) ? et : 0); end
            n_cmp++; if (g !== e)   begin n_mis++; $display("FAIL rand_rsp n=%0d: got %h expected %h", n, g, e); end
            n_cmp++; if (pb !== 0 || bi !== 1'b1) begin n_mis++; $display("FAIL rand_protocol n=%0d: got %0d/%b expected 0/1", n, pb, bi); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait3();
        test_unmapped();
        test_timeout_back_to_back();
        test_ready_at_timeout();
        test_backpressure();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
